// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns a command handshake into pipelined SINGLE/INCR bursts,
// honouring slave wait states and the two-cycle ERROR response.
module ahb_lite_master #(
    parameter int unsigned MAXLEN = 16
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] wr_data,
    output logic        wr_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic [31:0] Haddr,
    output logic [1:0]  Htrans,
    output logic        Hwrite,
    output logic [2:0]  Hsize,
    output logic [2:0]  Hburst,
    output logic [31:0] Hwdata,
    input  logic        Hready,
    input  logic [31:0] Hrdata,
    input  logic [1:0]  Hresp
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [1:0] RespOkay    = 2'b00;
    localparam logic [1:0] RespError   = 2'b01;
    localparam logic [2:0] BurstSingle = 3'b000;
    localparam logic [2:0] BurstIncr   = 3'b001;

    typedef enum logic [2:0] {StIdle, StAddr, StPipe, StData, StErr} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_haddr, w_haddr_next;
    logic [1:0]  r_htrans, w_htrans_next;
    logic        r_hwrite, w_hwrite_next;
    logic [2:0]  r_hburst, w_hburst_next;
    logic [31:0] r_hwdata, w_hwdata_next;
    logic [31:0] r_rd_data, w_rd_data_next;
    logic        r_rd_valid, w_rd_valid_next;
    logic        r_done, w_done_next;
    logic        r_err, w_err_next;
    logic        r_cmd_ready, w_cmd_ready_next;
    // Address phases still to be issued after the one currently on the bus.
    logic [4:0]  r_acnt, w_acnt_next;

    logic [4:0]  w_len;
    logic [31:0] w_addr_inc;
    logic [1:0]  w_inc_trans;
    logic        w_resp_err;
    logic        w_rd_ok;

    always_comb begin
        if (cmd_len == 5'd0) begin
            w_len = 5'd1;
        end else if (32'(cmd_len) > MAXLEN) begin
            w_len = 5'(MAXLEN);
        end else begin
            w_len = cmd_len;
        end
    end

    assign w_addr_inc  = r_haddr + 32'd4;
    // A beat that lands on a 1KB boundary must restart the burst.
    assign w_inc_trans = (w_addr_inc[9:0] == 10'd0) ? TransNonseq : TransSeq;
    assign w_resp_err  = (Hresp == RespError);
    assign w_rd_ok     = !r_hwrite && Hready && (Hresp == RespOkay);

    always_comb begin
        w_state_next     = r_state;
        w_haddr_next     = r_haddr;
        w_htrans_next    = r_htrans;
        w_hwrite_next    = r_hwrite;
        w_hburst_next    = r_hburst;
        w_hwdata_next    = r_hwdata;
        w_rd_data_next   = r_rd_data;
        w_rd_valid_next  = 1'b0;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;
        w_cmd_ready_next = 1'b0;
        w_acnt_next      = r_acnt;
        wr_pop           = 1'b0;

        case (r_state)
            StIdle: begin
                w_cmd_ready_next = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_state_next     = StAddr;
                    w_cmd_ready_next = 1'b0;
                    w_haddr_next     = {cmd_addr[31:2], 2'b00};
                    w_htrans_next    = TransNonseq;
                    w_hwrite_next    = cmd_write;
                    w_hburst_next    = (w_len == 5'd1) ? BurstSingle : BurstIncr;
                    w_acnt_next      = w_len - 5'd1;
                end
            end

            StAddr, StPipe: begin
                if ((r_state == StPipe) && w_resp_err) begin
                    w_htrans_next = TransIdle;
                    if (Hready) begin
                        w_state_next     = StIdle;
                        w_done_next      = 1'b1;
                        w_err_next       = 1'b1;
                        w_cmd_ready_next = 1'b1;
                    end else begin
                        w_state_next = StErr;
                    end
                end else if (Hready) begin
                    if ((r_state == StPipe) && w_rd_ok) begin
                        w_rd_data_next  = Hrdata;
                        w_rd_valid_next = 1'b1;
                    end
                    if (r_hwrite) begin
                        wr_pop        = 1'b1;
                        w_hwdata_next = wr_data;
                    end
                    if (r_acnt == 5'd0) begin
                        w_state_next  = StData;
                        w_htrans_next = TransIdle;
                    end else begin
                        w_state_next  = StPipe;
                        w_haddr_next  = w_addr_inc;
                        w_htrans_next = w_inc_trans;
                        w_acnt_next   = r_acnt - 5'd1;
                    end
                end
            end

            StData: begin
                if (w_resp_err) begin
                    if (Hready) begin
                        w_state_next     = StIdle;
                        w_done_next      = 1'b1;
                        w_err_next       = 1'b1;
                        w_cmd_ready_next = 1'b1;
                    end else begin
                        w_state_next = StErr;
                    end
                end else if (Hready) begin
                    if (w_rd_ok) begin
                        w_rd_data_next  = Hrdata;
                        w_rd_valid_next = 1'b1;
                    end
                    w_state_next     = StIdle;
                    w_done_next      = 1'b1;
                    w_cmd_ready_next = 1'b1;
                end
            end

            StErr: begin
                if (Hready) begin
                    w_state_next     = StIdle;
                    w_done_next      = 1'b1;
                    w_err_next       = 1'b1;
                    w_cmd_ready_next = 1'b1;
                end
            end

            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state     <= StIdle;
            r_haddr     <= 32'd0;
            r_htrans    <= TransIdle;
            r_hwrite    <= 1'b0;
            r_hburst    <= BurstSingle;
            r_hwdata    <= 32'd0;
            r_rd_data   <= 32'd0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_acnt      <= 5'd0;
        end else begin
            r_state     <= w_state_next;
            r_haddr     <= w_haddr_next;
            r_htrans    <= w_htrans_next;
            r_hwrite    <= w_hwrite_next;
            r_hburst    <= w_hburst_next;
            r_hwdata    <= w_hwdata_next;
            r_rd_data   <= w_rd_data_next;
            r_rd_valid  <= w_rd_valid_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_cmd_ready <= w_cmd_ready_next;
            r_acnt      <= w_acnt_next;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign Haddr     = r_haddr;
    assign Htrans    = r_htrans;
    assign Hwrite    = r_hwrite;
    assign Hsize     = 3'b010;
    assign Hburst    = r_hburst;
    assign Hwdata    = r_hwdata;

endmodule
